// File: rtl/menu_pkg.sv
// Shared constants for the menu command path: the valid command byte range,
// the per-key command bytes used by the menu controller, and the default
// received-byte width.
package menu_pkg;

    localparam int DEFAULT_DBIT = 8;

    // Command bytes accepted by the menu controller ('1'..'7')
    localparam logic [7:0] CMD_MIN = 8'h31;
    localparam logic [7:0] CMD_MAX = 8'h37;

    typedef enum logic [7:0] {
        KEY_1 = 8'h31,
        KEY_2 = 8'h32,
        KEY_3 = 8'h33,
        KEY_4 = 8'h34,
        KEY_5 = 8'h35,
        KEY_6 = 8'h36,
        KEY_7 = 8'h37
    } menu_key_e;

endpackage

// File: rtl/cmd_fifo_mem.sv
// Storage array for the menu command FIFO: one synchronous write port and
// one asynchronous read port. The array itself is never reset; validity of
// its contents is tracked by the pointer logic in menu_cmd_fifo.
module cmd_fifo_mem
    import menu_pkg::*;
#(
    parameter int DBIT   = DEFAULT_DBIT,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DBIT-1:0]   wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DBIT-1:0]   rdata
);

    logic [DBIT-1:0] mem [2**ADDR_W];

    // Write the incoming byte into the addressed slot
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/menu_cmd_fifo.sv
// Receive-side command buffer between uart_rx and the menu controller.
// Every byte strobed by rx_done_tick is queued and the oldest one is offered
// to the controller with a first-word-fall-through valid/ready handshake.
// Optional feature: define MENU_CMD_FILTER_EN to keep only command bytes
// '1'..'7' and count the discarded ones in reject_count.
module menu_cmd_fifo
    import menu_pkg::*;
#(
    parameter int DBIT   = DEFAULT_DBIT,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_done_tick,
    input  logic [DBIT-1:0]   rx_data,
    input  logic              flush,
    input  logic              cmd_ready,
    output logic              cmd_valid,
    output logic [DBIT-1:0]   cmd_data,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic [7:0]        reject_count
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DBIT-1:0]   mem_rdata;
    logic              byte_ok;
    logic              accept;
    logic              pop;
    logic              wr_en;

    // A flush cycle swallows any arriving byte and any pop request
`ifdef MENU_CMD_FILTER_EN
    assign byte_ok = (rx_data >= DBIT'(CMD_MIN)) && (rx_data <= DBIT'(CMD_MAX));
`else
    assign byte_ok = 1'b1;
`endif
    assign accept = rx_done_tick && byte_ok && !flush;
    assign pop    = !empty && cmd_ready && !flush;
    assign wr_en  = accept && (!full || pop);

    assign empty     = (level == '0);
    assign full      = (level == DEPTH);
    assign cmd_valid = !empty;
    assign cmd_data  = empty ? '0 : mem_rdata;

    cmd_fifo_mem #(
        .DBIT   (DBIT),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (rx_data),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    // Pointer and occupancy bookkeeping; pointers wrap naturally at 2^ADDR_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky drop flag: set only when an accepted byte finds no room
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (accept && full && !pop) begin
            overflow <= 1'b1;
        end
    end

`ifdef MENU_CMD_FILTER_EN
    // Saturating count of non-command bytes thrown away by the filter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reject_count <= '0;
        end else if (flush) begin
            reject_count <= '0;
        end else if (rx_done_tick && !byte_ok && (reject_count != 8'hFF)) begin
            reject_count <= reject_count + 1'b1;
        end
    end
`else
    assign reject_count = '0;
`endif

endmodule
